// File: rtl/mem_pkg.sv
// Shared memory-unit encodings and IR field layout.
// Also used by control_unit.
package mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;

  localparam int OP_HI    = 15;
  localparam int OP_LO    = 11;
  localparam int FLAG_POS = 10;
  localparam int IMM_HI   = 9;
  localparam int IMM_LO   = 0;
  localparam int IMM_W    = IMM_HI - IMM_LO + 1;

  typedef enum logic [2:0] {
    DST_PC      = 3'b000,
    DST_IMM     = 3'b001,
    DST_MARY    = 3'b010,
    DST_SHELLEY = 3'b011,
    DST_SP      = 3'b100,
    DST_SP1     = 3'b101
  } memDst_e;

  typedef enum logic [2:0] {
    SRC_MARY    = 3'b000,
    SRC_SHELLEY = 3'b001,
    SRC_RA      = 3'b010,
    SRC_PC      = 3'b011,
    SRC_IMM     = 3'b100
  } memSrc_e;

endpackage

// File: rtl/mem_unit_ram_sp.sv
// Single-port RAM, synchronous write and read.
// Read data register updates only on rdEn.
module ram_sp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array write and registered read share one port.
  always_ff @(posedge clk) begin
    if (wrEn) mem[addr] <= wrData;
    if (rdEn) rdData <= mem[addr];
  end

endmodule

// File: rtl/mem_unit.sv
// Memory unit: address/data select, MDR, IR, error flag.
// RAM storage lives in ram_sp.
module mem_unit
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        MemDst,
  input  logic [2:0]        MemSrc,
  input  logic              IRWrite,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] SP,
  input  logic [DATA_W-1:0] Mary,
  input  logic [DATA_W-1:0] Shelley,
  input  logic [DATA_W-1:0] RA,
  output logic [4:0]        OPCODE,
  output logic              flagbit,
  output logic [9:0]        Imm,
  output logic [DATA_W-1:0] MemData,
  output logic              MemErr
);

  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mdrReg;
  logic              mdrFromRam;
  logic              memErr;
  logic [DATA_W-1:0] immExt;
  logic [DATA_W-1:0] addrFull;
  logic [DATA_W-1:0] wrData;
  logic [DATA_W-1:0] ramQ;
  logic [ADDR_W-1:0] ramAddr;
  logic              dstOk;
  logic              srcOk;
  logic              rdOk;
  logic              wrOk;
  logic              illegal;
  logic              unusedAddrHi;

  assign OPCODE  = ir[OP_HI:OP_LO];
  assign flagbit = ir[FLAG_POS];
  assign Imm     = ir[IMM_HI:IMM_LO];
  assign immExt  = {{(DATA_W-IMM_W){1'b0}}, Imm};

  // Address source select; upper bits dropped so addresses wrap.
  always_comb begin
    addrFull = '0;
    dstOk    = 1'b1;
    case (MemDst)
      DST_PC:      addrFull = PC;
      DST_IMM:     addrFull = immExt;
      DST_MARY:    addrFull = Mary;
      DST_SHELLEY: addrFull = Shelley;
      DST_SP:      addrFull = SP;
      DST_SP1:     addrFull = SP + DATA_W'(1);
      default:     dstOk    = 1'b0;
    endcase
  end

  assign ramAddr      = addrFull[ADDR_W-1:0];
  assign unusedAddrHi = ^addrFull[DATA_W-1:ADDR_W];

  // Write data source select.
  always_comb begin
    wrData = '0;
    srcOk  = 1'b1;
    case (MemSrc)
      SRC_MARY:    wrData = Mary;
      SRC_SHELLEY: wrData = Shelley;
      SRC_RA:      wrData = RA;
      SRC_PC:      wrData = PC;
      SRC_IMM:     wrData = immExt;
      default:     srcOk  = 1'b0;
    endcase
  end

  assign rdOk = Reset & MemRead & ~MemWrite & dstOk;
  assign wrOk = Reset & MemWrite & ~MemRead & dstOk & srcOk;

  assign illegal = (MemRead & MemWrite)
                 | ((MemRead | MemWrite) & ~dstOk)
                 | (MemWrite & ~srcOk);

  ram_sp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) uRam (
    .clk    (CLK),
    .wrEn   (wrOk),
    .rdEn   (rdOk),
    .addr   (ramAddr),
    .wrData (wrData),
    .rdData (ramQ)
  );

  // The RAM's read register acts as MDR until the next
  // non-read edge, when it is copied into mdrReg and held.
  assign MemData = mdrFromRam ? ramQ : mdrReg;
  assign MemErr  = memErr;

  // MDR, IR and sticky error flag.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      ir         <= '0;
      mdrReg     <= '0;
      mdrFromRam <= 1'b0;
      memErr     <= 1'b0;
    end else begin
      if (IRWrite) ir <= MemData;
      if (rdOk) begin
        mdrFromRam <= 1'b1;
      end else if (mdrFromRam) begin
        mdrReg     <= ramQ;
        mdrFromRam <= 1'b0;
      end
      if (illegal) memErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_unit.sv
// Directed plus random bench for mem_unit.
// Reference model tracks RAM words, MDR, IR, MemErr.
module tb_mem_unit;

  logic        CLK;
  logic        Reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  MemDst;
  logic [2:0]  MemSrc;
  logic        IRWrite;
  logic [15:0] PC;
  logic [15:0] SP;
  logic [15:0] Mary;
  logic [15:0] Shelley;
  logic [15:0] RA;
  logic [4:0]  OPCODE;
  logic        flagbit;
  logic [9:0]  Imm;
  logic [15:0] MemData;
  logic        MemErr;

  int nAssert = 0;
  int nFail   = 0;

  logic [15:0] mRam [1024];
  bit          mWr  [1024];
  logic [15:0] mMdr;
  bit          mMdrKnown;
  logic [15:0] mIr;
  bit          mIrKnown;
  bit          mErr;

  mem_unit dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .MemDst   (MemDst),
    .MemSrc   (MemSrc),
    .IRWrite  (IRWrite),
    .PC       (PC),
    .SP       (SP),
    .Mary     (Mary),
    .Shelley  (Shelley),
    .RA       (RA),
    .OPCODE   (OPCODE),
    .flagbit  (flagbit),
    .Imm      (Imm),
    .MemData  (MemData),
    .MemErr   (MemErr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit rd,
                       input bit wr, input int dst,
                       input int src, input bit irw);
    Reset    = rst;
    MemRead  = rd;
    MemWrite = wr;
    MemDst   = 3'(dst);
    MemSrc   = 3'(src);
    IRWrite  = irw;
  endtask

  // Reference behaviour of one clock edge.
  task automatic model();
    int   a;
    bit   dOk;
    bit   sOk;
    logic [15:0] d;
    logic [15:0] oldMdr;
    bit   oldKnown;
    if (!Reset) begin
      mMdr = 0; mMdrKnown = 1;
      mIr  = 0; mIrKnown  = 1;
      mErr = 0;
      return;
    end
    dOk = (int'(MemDst) <= 5);
    sOk = (int'(MemSrc) <= 4);
    case (int'(MemDst))
      0: a = int'(PC);
      1: a = int'(mIr) % 1024;
      2: a = int'(Mary);
      3: a = int'(Shelley);
      4: a = int'(SP);
      5: a = (int'(SP) + 1) % 65536;
      default: a = 0;
    endcase
    a = a % 1024;
    case (int'(MemSrc))
      0: d = Mary;
      1: d = Shelley;
      2: d = RA;
      3: d = PC;
      4: d = 16'(int'(mIr) % 1024);
      default: d = 0;
    endcase
    oldMdr = mMdr;
    oldKnown = mMdrKnown;
    if (MemRead && MemWrite) mErr = 1;
    else if ((MemRead || MemWrite) && !dOk) mErr = 1;
    else if (MemWrite && !sOk) mErr = 1;
    else if (MemWrite) begin
      mRam[a] = d; mWr[a] = 1;
    end else if (MemRead) begin
      mMdr = mRam[a]; mMdrKnown = mWr[a];
    end
    if (IRWrite) begin
      mIr = oldMdr; mIrKnown = oldKnown;
    end
  endtask

  task automatic step(input string tag);
    model();
    @(posedge CLK);
    #1;
    chk({tag, ".err"}, 32'(MemErr), 32'(mErr));
    if (mMdrKnown)
      chk({tag, ".mdr"}, 32'(MemData), 32'(mMdr));
    if (mIrKnown) begin
      chk({tag, ".op"}, 32'(OPCODE), 32'(mIr[15:11]));
      chk({tag, ".flag"}, 32'(flagbit), 32'(mIr[10]));
      chk({tag, ".imm"}, 32'(Imm), 32'(mIr[9:0]));
    end
  endtask

  function automatic logic [15:0] rv();
    logic [15:0] v;
    v = 16'($urandom);
    v[9:0] = 10'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    int   r;
    int   dst;
    int   src;
    bit   rd;
    bit   wr;
    for (int i = 0; i < 1024; i++) mWr[i] = 0;
    mMdr = 0; mMdrKnown = 0;
    mIr = 0; mIrKnown = 0; mErr = 0;
    PC = 0; SP = 0; Mary = 0; Shelley = 0; RA = 0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    step("rst0");
    step("rst1");
    chk("rst.mdr", 32'(MemData), 0);
    chk("rst.op", 32'(OPCODE), 0);
    chk("rst.err", 32'(MemErr), 0);

    Mary = 16'h1234;
    drive(1, 0, 1, 2, 0, 0); step("wr1234");
    drive(1, 1, 0, 2, 0, 0); step("rd1234");
    chk("rd1234.exact", 32'(MemData), 32'h1234);

    PC = 16'd5; RA = 16'h5405;
    drive(1, 0, 1, 0, 2, 0); step("wr5");
    drive(1, 1, 0, 0, 0, 0); step("rd5");
    drive(1, 0, 0, 0, 0, 1); step("ir5");
    chk("ir5.op", 32'(OPCODE), 32'd10);
    chk("ir5.flag", 32'(flagbit), 1);
    chk("ir5.imm", 32'(Imm), 32'h005);

    Mary = 16'h0000; Shelley = 16'hBEEF;
    drive(1, 0, 1, 2, 1, 0); step("wr0");
    SP = 16'hFFFF;
    drive(1, 1, 0, 5, 0, 0); step("sp1wrap");
    chk("sp1wrap.exact", 32'(MemData), 32'hBEEF);
    drive(1, 1, 0, 0, 0, 0); step("rd5b");
    SP = 16'h0400;
    drive(1, 1, 0, 4, 0, 0); step("spwrap");
    chk("spwrap.exact", 32'(MemData), 32'hBEEF);

    Mary = 16'd5;
    drive(1, 1, 1, 2, 0, 0); step("both");
    chk("both.mdr", 32'(MemData), 32'hBEEF);
    chk("both.err", 32'(MemErr), 1);
    drive(1, 1, 0, 2, 0, 0); step("bothchk");
    chk("bothchk.ram", 32'(MemData), 32'h5405);
    drive(1, 0, 0, 0, 0, 0); step("sticky");
    chk("sticky.err", 32'(MemErr), 1);
    drive(0, 0, 0, 0, 0, 0); step("rstA");

    drive(1, 1, 0, 6, 0, 0); step("dst6");
    chk("dst6.err", 32'(MemErr), 1);
    chk("dst6.mdr", 32'(MemData), 0);
    drive(0, 0, 0, 0, 0, 0); step("rstB");
    Mary = 16'h0000;
    drive(1, 0, 1, 2, 7, 0); step("src7");
    chk("src7.err", 32'(MemErr), 1);
    drive(1, 1, 0, 2, 0, 0); step("src7chk");
    chk("src7chk.ram", 32'(MemData), 32'hBEEF);

    drive(1, 0, 0, 0, 0, 1); step("preIr");
    Shelley = 16'h1111;
    drive(0, 0, 1, 2, 1, 0); step("rstW0");
    step("rstW1");
    chk("rstW.mdr", 32'(MemData), 0);
    chk("rstW.imm", 32'(Imm), 0);
    chk("rstW.err", 32'(MemErr), 0);
    drive(1, 1, 0, 2, 0, 0); step("rstWchk");
    chk("rstWchk.ram", 32'(MemData), 32'hBEEF);

    for (int n = 0; n < 400; n++) begin
      PC = rv(); Mary = rv(); Shelley = rv(); RA = 16'($urandom);
      SP = ($urandom_range(0, 7) == 0) ? 16'hFFFF : rv();
      r = $urandom_range(0, 9);
      rd = (r <= 3) || (r == 8);
      wr = (r >= 4 && r <= 8);
      dst = $urandom_range(0, 15);
      if (dst > 7) dst = dst % 6;
      src = $urandom_range(0, 15);
      if (src > 7) src = src % 5;
      if (!mIrKnown && dst == 1) dst = 0;
      if (!mIrKnown && src == 4) src = 0;
      drive($urandom_range(0, 31) != 0, rd, wr, dst, src,
            $urandom_range(0, 3) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/mem_unit.md
MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16: word width.
REQ-002 SHALL have parameter ADDR_W, default 10: RAM word-address width, giving 1024 words.
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port MemRead, input, 1: read strobe from control_unit.
REQ-006 SHALL have port MemWrite, input, 1: write strobe from control_unit.
REQ-007 SHALL have port MemDst, input, 3: address-source select.
REQ-008 SHALL have port MemSrc, input, 3: write-data-source select.
REQ-009 SHALL have port IRWrite, input, 1: instruction-register load enable.
REQ-010 SHALL have ports PC, SP, Mary, Shelley, RA, each input, DATA_W: datapath register values.
REQ-011 SHALL have port OPCODE, output, 5: IR[15:11], to control_unit.
REQ-012 SHALL have port flagbit, output, 1: IR[10], to control_unit.
REQ-013 SHALL have port Imm, output, 10: IR[9:0].
REQ-014 SHALL have port MemData, output, DATA_W: memory data register (MDR).
REQ-015 SHALL have port MemErr, output, 1: sticky illegal-access flag.

Function
REQ-016 SHALL decode MemDst as: 000 PC, 001 zero-extended Imm, 010 Mary, 011 Shelley, 100 SP, 101 SP+1 (16-bit wrap, so 0xFFFF+1 = 0x0000); 110 and 111 are illegal.
REQ-017 SHALL form the RAM address from the low ADDR_W bits of the selected source; higher bits are ignored, so addresses wrap.
REQ-018 SHALL decode MemSrc as: 000 Mary, 001 Shelley, 010 RA, 011 PC, 100 zero-extended Imm; 101-111 are illegal.
REQ-019 SHALL write the selected data to RAM at the rising edge ending a cycle with MemWrite=1, a legal MemDst, a legal MemSrc, and MemRead=0.
REQ-020 SHALL load MDR with RAM[addr] at the edge ending a cycle with MemRead=1, a legal MemDst, and MemWrite=0; MemData is valid in the following cycle (read latency 1).
REQ-021 SHALL hold MDR in every cycle with no legal read.
REQ-022 SHALL load IR from MemData at the edge ending a cycle with IRWrite=1, and hold IR otherwise.
REQ-023 SHALL, when IRWrite and MemRead are both 1 in the same cycle, load IR with the old MDR value while MDR takes the new value.
REQ-024 SHALL drive OPCODE, flagbit and Imm combinationally from IR.
REQ-025 SHALL treat MemRead=1 and MemWrite=1 in the same cycle as illegal: suppress the write, hold MDR, and set MemErr.
REQ-026 SHALL treat a strobe with an illegal MemDst, or a write with an illegal MemSrc, as illegal: no access, and set MemErr.
REQ-027 SHALL keep MemErr set until Reset.

Reset
REQ-028 SHALL, when Reset=0 at an edge, clear MDR, IR (so OPCODE=0, flagbit=0, Imm=0) and MemErr.
REQ-029 SHALL suppress any write in a cycle with Reset=0.
REQ-030 SHALL leave RAM contents unchanged by reset; contents are not initialised.

Structure
REQ-031 SHALL take the MemDst/MemSrc encodings, the IR field positions, and the DATA_W/ADDR_W defaults from a shared package, mem_pkg, which control_unit also uses.
REQ-032 SHALL use one sub-module, ram_sp: single-port RAM with synchronous write and synchronous read of 2^ADDR_W x DATA_W; all select logic, MDR, IR and the error flag stay in mem_unit.

Verification
REQ-033 SHALL check: Mary=0x1234, MemDst=010, MemSrc=000, write; then read at the same address -> MemData=0x1234 one cycle after the read strobe.
REQ-034 SHALL check: RAM[5]=0x5405 (OPCODE 10, flagbit 1, Imm 5), PC=5, read, then IRWrite -> OPCODE=01010, flagbit=1, Imm=0x005.
REQ-035 SHALL check: SP=0xFFFF, MemDst=101, read -> RAM[0] returned; SP=0x0400, MemDst=100 -> RAM[0] returned (address wrap).
REQ-036 SHALL check: MemRead=1 and MemWrite=1 together -> target word unchanged, MDR held, MemErr=1 until Reset.
REQ-037 SHALL check: MemDst=110 read, or MemSrc=111 write -> no access, MemErr=1.
REQ-038 SHALL check: Reset=0 held for 2 cycles during a write -> write suppressed, and MDR, IR, MemErr all 0.
